// File: rtl/mem_pkg.sv
// Shared types, constants and decode helpers for the MEM-stage load/store engine.
package mem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } mem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULTSRC_MEM = 2'b01;

   // Stores only know B/H/W; loads additionally know the unsigned variants.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!is_store) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

   // Halfwords need an even address, words need a word-aligned address.
   function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
      logic ok;
      ok = 1'b1;
      if (f3 == F3_H || f3 == F3_HU) begin
         ok = (lo[0] == 1'b0);
      end else if (f3 == F3_W) begin
         ok = (lo == 2'b00);
      end
      return ok;
   endfunction

   // Byte enables by access size and byte offset.
   function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
      logic [BE_W-1:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << lo;
         2'b01:   be = 4'b0011 << {lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated onto every lane the access could target.
   function automatic logic [WORD_W-1:0] lane_data(input logic [2:0] f3, input logic [WORD_W-1:0] wd);
      logic [WORD_W-1:0] d;
      case (f3[1:0])
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero-extends it.
module load_extend
   import mem_pkg::*;
(
   input  logic [WORD_W-1:0] rdata,
   input  logic [1:0]        addr_lo,
   input  logic [2:0]        funct3,
   output logic [WORD_W-1:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane selection from the byte offset of the original address.
   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'b00: byte_lane = rdata[7:0];
         2'b01: byte_lane = rdata[15:8];
         2'b10: byte_lane = rdata[23:16];
         2'b11: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extension by access type; words pass straight through.
   always_comb begin
      result = rdata;
      case (funct3)
         F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
         F3_BU:   result = {24'b0, byte_lane};
         F3_H:    result = {{16{half_lane[15]}}, half_lane};
         F3_HU:   result = {16'b0, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns EX/MEM control into bus transactions and stalls until done.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              memwritem_i,
   input  logic [1:0]        resultsrcm_i,
   input  logic [2:0]        funct3m_i,
   input  logic [ADDR_W-1:0] aluresultm_i,
   input  logic [DATA_W-1:0] writedatam_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] readdatam_o,
   output logic              err_o,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   output logic              req_we_o,
   output logic [ADDR_W-1:0] req_addr_o,
   output logic [3:0]        req_be_o,
   output logic [DATA_W-1:0] req_wdata_o,
   input  logic              rsp_valid_i,
   input  logic [DATA_W-1:0] rsp_rdata_i
);

   mem_state_t  state;
   logic [2:0]  f3_q;
   logic [1:0]  addr_lo_q;

   logic              is_store;
   logic              is_load;
   logic              access;
   logic              acc_ok;
   logic              acc_bad;
   logic [DATA_W-1:0] load_result;

   // Decode of the instruction currently sitting in MEM; a store wins over a load.
   always_comb begin
      is_store = memwritem_i;
      is_load  = (resultsrcm_i == RESULTSRC_MEM);
      access   = is_store | is_load;
      acc_ok   = access && f3_legal(is_store, funct3m_i) && f3_aligned(funct3m_i, aluresultm_i[1:0]);
      acc_bad  = access && !acc_ok;
   end

   // Hold the pipeline from the first cycle of a legal access until DONE; never during reset.
   assign stall_o = reset_ni && (((state == IDLE) && acc_ok) || (state == REQ) || (state == WAIT));

   load_extend u_load_extend (
      .rdata   (rsp_rdata_i),
      .addr_lo (addr_lo_q),
      .funct3  (f3_q),
      .result  (load_result)
   );

   // Transaction FSM with registered bus request, load result and error pulse.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state       <= IDLE;
         f3_q        <= 3'b0;
         addr_lo_q   <= 2'b0;
         req_valid_o <= 1'b0;
         req_we_o    <= 1'b0;
         req_addr_o  <= '0;
         req_be_o    <= 4'b0;
         req_wdata_o <= '0;
         readdatam_o <= '0;
         err_o       <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (acc_ok) begin
                  req_valid_o <= 1'b1;
                  req_we_o    <= is_store;
                  req_addr_o  <= {aluresultm_i[ADDR_W-1:2], 2'b00};
                  req_be_o    <= byte_en(funct3m_i, aluresultm_i[1:0]);
                  req_wdata_o <= lane_data(funct3m_i, writedatam_i);
                  f3_q        <= funct3m_i;
                  addr_lo_q   <= aluresultm_i[1:0];
                  state       <= REQ;
               end else if (acc_bad) begin
                  err_o <= 1'b1;
               end
            end
            REQ: begin
               if (req_ready_i) begin
                  req_valid_o <= 1'b0;
                  state       <= req_we_o ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (rsp_valid_i) begin
                  readdatam_o <= load_result;
                  state       <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions, a bus responder and a monitor.
module tb_mem_access_unit;

   logic        clk_i;
   logic        reset_ni;
   logic        memwritem_i;
   logic [1:0]  resultsrcm_i;
   logic [2:0]  funct3m_i;
   logic [31:0] aluresultm_i;
   logic [31:0] writedatam_i;
   logic        stall_o;
   logic [31:0] readdatam_o;
   logic        err_o;
   logic        req_valid_o;
   logic        req_ready_i;
   logic        req_we_o;
   logic [31:0] req_addr_o;
   logic [3:0]  req_be_o;
   logic [31:0] req_wdata_o;
   logic        rsp_valid_i;
   logic [31:0] rsp_rdata_i;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .memwritem_i  (memwritem_i),
      .resultsrcm_i (resultsrcm_i),
      .funct3m_i    (funct3m_i),
      .aluresultm_i (aluresultm_i),
      .writedatam_i (writedatam_i),
      .stall_o      (stall_o),
      .readdatam_o  (readdatam_o),
      .err_o        (err_o),
      .req_valid_o  (req_valid_o),
      .req_ready_i  (req_ready_i),
      .req_we_o     (req_we_o),
      .req_addr_o   (req_addr_o),
      .req_be_o     (req_be_o),
      .req_wdata_o  (req_wdata_o),
      .rsp_valid_i  (rsp_valid_i),
      .rsp_rdata_i  (rsp_rdata_i)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic [31:0] rd;
      int          stalls;
   } done_t;

   req_t  req_q[$];
   done_t done_q[$];

   int total = 0;
   int bad   = 0;
   int err_exp  = 0;
   int err_seen = 0;

   int          ready_lat = 0;
   int          rsp_lat   = 1;
   logic [31:0] rsp_word  = 32'h0;
   logic        manual    = 1'b0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus responder: ready after ready_lat REQ cycles, read data rsp_lat cycles after the handshake.
   initial begin
      logic hs_rd;
      logic in_wait;
      int   wcnt;
      int   rcnt;
      in_wait = 1'b0;
      wcnt = 0;
      rcnt = 0;
      forever begin
         @(negedge clk_i);
         hs_rd = req_valid_o && req_ready_i && !req_we_o;
         @(posedge clk_i);
         #2;
         if (!manual) begin
            rsp_valid_i = 1'b0;
            if (hs_rd) begin
               in_wait = 1'b1;
               wcnt = 0;
            end
            if (in_wait) begin
               wcnt++;
               if (wcnt == rsp_lat) begin
                  rsp_valid_i = 1'b1;
                  rsp_rdata_i = rsp_word;
                  in_wait = 1'b0;
               end
            end
            if (req_valid_o) begin
               rcnt++;
               req_ready_i = (rcnt > ready_lat);
            end else begin
               rcnt = 0;
               req_ready_i = (ready_lat == 0);
            end
         end
      end
   end

   // Monitor: request handshakes, request stability, stall length and load result at DONE, error pulses.
   initial begin
      int   stall_run;
      logic hold_v;
      req_t hold;
      req_t cur;
      req_t e;
      done_t d;
      stall_run = 0;
      hold_v = 1'b0;
      hold = '0;
      forever begin
         @(negedge clk_i);
         if (!reset_ni) begin
            stall_run = 0;
            hold_v = 1'b0;
         end else begin
            if (err_o) err_seen++;
            if (stall_o) begin
               stall_run++;
            end else if (stall_run > 0) begin
               if (done_q.size() == 0) begin
                  check("unexpected_done", 32'(stall_run), 32'd0);
               end else begin
                  d = done_q.pop_front();
                  check("stall_cycles", 32'(stall_run), 32'(d.stalls));
                  check("readdata", readdatam_o, d.rd);
               end
               stall_run = 0;
            end
            if (req_valid_o) begin
               cur = {req_we_o, req_addr_o, req_be_o, req_wdata_o};
               if (hold_v) check("req_stable", 32'(cur == hold), 32'd1);
               if (req_ready_i) begin
                  hold_v = 1'b0;
                  if (req_q.size() == 0) begin
                     check("unexpected_req", req_addr_o, 32'hFFFF_FFFF);
                  end else begin
                     e = req_q.pop_front();
                     check("req_we", 32'(req_we_o), 32'(e.we));
                     check("req_addr", req_addr_o, e.addr);
                     if (e.we) begin
                        check("req_be", 32'(req_be_o), 32'(e.be));
                        check("req_wdata", req_wdata_o, e.wdata);
                     end
                  end
               end else begin
                  hold_v = 1'b1;
                  hold = cur;
               end
            end else begin
               hold_v = 1'b0;
            end
         end
      end
   end

   task automatic clear_instr();
      memwritem_i  = 1'b0;
      resultsrcm_i = 2'b00;
      funct3m_i    = 3'b000;
      aluresultm_i = 32'h0;
      writedatam_i = 32'h0;
   endtask

   // Issue one legal access and hold it in MEM until the stall releases.
   task automatic run_instr(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int rl, input int rsl, input logic [31:0] rword,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                            input int exp_stalls);
      req_t  r;
      done_t d;
      logic  st;
      int    n;
      r = {we, exp_addr, exp_be, exp_wdata};
      d.rd = exp_rd;
      d.stalls = exp_stalls;
      req_q.push_back(r);
      done_q.push_back(d);
      ready_lat = rl;
      rsp_lat = rsl;
      rsp_word = rword;
      memwritem_i  = we;
      resultsrcm_i = rs;
      funct3m_i    = f3;
      aluresultm_i = addr;
      writedatam_i = wd;
      n = 0;
      do begin
         @(negedge clk_i);
         st = stall_o;
         @(posedge clk_i);
         #1;
         n++;
      end while (st && n < 200);
      if (st) check("instr_timeout", 32'(n), 32'd0);
      clear_instr();
   endtask

   // Issue one illegal or misaligned access: no stall now, one error pulse next cycle.
   task automatic run_err(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                          input logic [31:0] addr);
      err_exp++;
      memwritem_i  = we;
      resultsrcm_i = rs;
      funct3m_i    = f3;
      aluresultm_i = addr;
      writedatam_i = 32'h1234_5678;
      @(negedge clk_i);
      check("err_nostall", 32'(stall_o), 32'd0);
      @(posedge clk_i);
      #1;
      clear_instr();
      @(negedge clk_i);
      check("err_pulse", 32'(err_o), 32'd1);
      check("err_noreq", 32'(req_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(req_valid_o), 32'd0);
      check({tag, "_we"}, 32'(req_we_o), 32'd0);
      check({tag, "_addr"}, req_addr_o, 32'd0);
      check({tag, "_be"}, 32'(req_be_o), 32'd0);
      check({tag, "_wdata"}, req_wdata_o, 32'd0);
      check({tag, "_rdata"}, readdatam_o, 32'd0);
      check({tag, "_err"}, 32'(err_o), 32'd0);
      check({tag, "_stall"}, 32'(stall_o), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      reset_ni    = 1'b0;
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_rdata_i = 32'h0;
      clear_instr();
      // A store presented during reset must not stall.
      memwritem_i = 1'b1;
      funct3m_i   = 3'b010;
      repeat (2) @(negedge clk_i);
      check_reset_outputs("rst");
      clear_instr();
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // SB 0x1003
      run_instr(1'b1, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 1, 32'h0,
                32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 2);
      // SW with load also flagged: treated as store
      run_instr(1'b1, 2'b01, 3'b010, 32'h0000_0020, 32'h1234_5678, 0, 1, 32'h0,
                32'h0000_0020, 4'b1111, 32'h1234_5678, 32'h0, 2);
      // LH / LHU 0x2002
      run_instr(1'b0, 2'b01, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234,
                32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001, 3);
      run_instr(1'b0, 2'b01, 3'b101, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_1234,
                32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001, 3);
      // LW with ready low 3 cycles and a 2-cycle response wait
      run_instr(1'b0, 2'b01, 3'b010, 32'h0000_3000, 32'h0, 3, 2, 32'hCAFE_F00D,
                32'h0000_3000, 4'b0000, 32'h0, 32'hCAFE_F00D, 7);
      // LBU top byte
      run_instr(1'b0, 2'b01, 3'b100, 32'h0000_2003, 32'h0, 0, 1, 32'h8001_1234,
                32'h0000_2000, 4'b0000, 32'h0, 32'h0000_0080, 3);

      // Illegal / misaligned accesses
      run_err(1'b0, 2'b01, 3'b010, 32'h0000_4002);
      run_err(1'b1, 2'b00, 3'b001, 32'h0000_4001);
      run_err(1'b0, 2'b01, 3'b011, 32'h0000_4000);
      run_err(1'b1, 2'b00, 3'b100, 32'h0000_4000);

      // Reset in the middle of WAIT, then a stray response
      manual = 1'b1;
      req_ready_i = 1'b1;
      rsp_valid_i = 1'b0;
      begin
         req_t r;
         r = {1'b0, 32'h0000_3000, 4'b0000, 32'h0};
         req_q.push_back(r);
      end
      memwritem_i  = 1'b0;
      resultsrcm_i = 2'b01;
      funct3m_i    = 3'b010;
      aluresultm_i = 32'h0000_3000;
      @(posedge clk_i);
      #1;
      @(posedge clk_i);
      #1;
      req_ready_i = 1'b0;
      @(negedge clk_i);
      check("wait_stall", 32'(stall_o), 32'd1);
      check("wait_novalid", 32'(req_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      reset_ni = 1'b0;
      clear_instr();
      #1;
      check("midrst_valid_drop", 32'(req_valid_o), 32'd0);
      @(negedge clk_i);
      check_reset_outputs("midrst");
      @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      @(posedge clk_i);
      #1;
      rsp_valid_i = 1'b1;
      rsp_rdata_i = 32'hDEAD_BEEF;
      @(posedge clk_i);
      #1;
      rsp_valid_i = 1'b0;
      @(negedge clk_i);
      check("stray_rdata", readdatam_o, 32'd0);
      check("stray_stall", 32'(stall_o), 32'd0);
      check("stray_valid", 32'(req_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      manual = 1'b0;
      @(posedge clk_i);
      #3;

      // Back-to-back LB 0x10 then SB 0x11
      run_instr(1'b0, 2'b01, 3'b000, 32'h0000_0010, 32'h0, 0, 1, 32'h0000_00F0,
                32'h0000_0010, 4'b0000, 32'h0, 32'hFFFF_FFF0, 3);
      run_instr(1'b1, 2'b00, 3'b000, 32'h0000_0011, 32'h0000_005A, 0, 1, 32'h0,
                32'h0000_0010, 4'b0010, 32'h5A5A_5A5A, 32'hFFFF_FFF0, 2);

      repeat (5) @(negedge clk_i);
      check("err_count", 32'(err_seen), 32'(err_exp));
      check("req_q_left", 32'(req_q.size()), 32'd0);
      check("done_q_left", 32'(done_q.size()), 32'd0);
      check("final_rdata", readdatam_o, 32'hFFFF_FFF0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
